// File: rtl/jpeg_dequant.sv
// Streaming JPEG inverse quantizer: two signed 16-bit coefficients per word times a 64-entry Q table.
// Define DEQUANT_SAT_EN to saturate each product to 16 bits instead of wrapping.
module jpeg_dequant_lane #(
   parameter int QW    = 8,
   parameter int VEC_W = 16
) (
   input  logic [VEC_W-1:0] coef,
   input  logic [QW-1:0]    q,
   output logic [VEC_W-1:0] res
);
`ifdef DEQUANT_SAT_EN
   localparam int PW = VEC_W + QW + 1;
   localparam logic signed [PW-1:0] MAXV = PW'({1'b0, {(VEC_W-1){1'b1}}});
   localparam logic signed [PW-1:0] MINV = -(MAXV + PW'(1));
   logic signed [PW-1:0] a, b, prod;
   assign a    = PW'($signed(coef));
   assign b    = PW'(q);
   assign prod = a * b;
   always_comb begin
      res = prod[VEC_W-1:0];
      if (prod > MAXV)      res = {1'b0, {(VEC_W-1){1'b1}}};
      else if (prod < MINV) res = {1'b1, {(VEC_W-1){1'b0}}};
   end
`else
   // Low VEC_W bits of a product do not depend on operand signedness.
   logic [VEC_W-1:0] qz;
   assign qz  = VEC_W'(q);
   assign res = coef * qz;
`endif
endmodule

module jpeg_dequant #(
   parameter int QW        = 8,
   parameter int BLK_WORDS = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          qt_we_i,
   input  logic [5:0]    qt_addr_i,
   input  logic [QW-1:0] qt_dat_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [31:0]   in_dat_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [31:0]   out_dat_o,
   output logic          out_last_o,
   output logic          busy_o
);
   localparam int NUM_LANES = 2;
   localparam int VEC_W     = 16;
   localparam int STAGES    = 2;
   localparam int CW        = $clog2(BLK_WORDS);

   typedef struct packed {
      logic [NUM_LANES-1:0][VEC_W-1:0] coef;
      logic [NUM_LANES-1:0][QW-1:0]    q;
      logic                            last;
   } s1_t;

   logic [QW-1:0]                   qt [64];
   logic [CW-1:0]                   wcnt;
   logic [STAGES:1]                 vld_pipe;
   logic                            en, hs;
   s1_t                             s1_d, s1_q;
   logic [NUM_LANES-1:0][VEC_W-1:0] lane_res;

   assign en          = !out_valid_o | out_ready_i;
   assign hs          = in_valid_i & en;
   assign in_ready_o  = en;
   assign out_valid_o = vld_pipe[STAGES];
   assign busy_o      = (wcnt != '0) | vld_pipe[1] | out_valid_o;

   // Writes are locked out while any block data is in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 64; i++) qt[i] <= QW'(1);
      end else if (qt_we_i && !busy_o) begin
         qt[qt_addr_i] <= qt_dat_i;
      end
   end

   // Lane 1 is the high half (even coefficient), lane 0 the low half (odd).
   always_comb begin
      s1_d      = '0;
      s1_d.coef = in_dat_i;
      for (int l = 0; l < NUM_LANES; l++) s1_d.q[l] = qt[{wcnt, 1'(l == 0)}];
      s1_d.last = (wcnt == CW'(BLK_WORDS - 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wcnt       <= '0;
         vld_pipe   <= '0;
         s1_q       <= '0;
         out_dat_o  <= '0;
         out_last_o <= 1'b0;
      end else if (en) begin
         if (in_valid_i) wcnt <= wcnt + CW'(1);
         vld_pipe   <= {vld_pipe[STAGES-1:1], in_valid_i};
         s1_q       <= s1_d;
         out_dat_o  <= lane_res;
         out_last_o <= s1_q.last & vld_pipe[1];
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      jpeg_dequant_lane #(.QW(QW), .VEC_W(VEC_W)) u_lane (
         .coef (s1_q.coef[l]),
         .q    (s1_q.q[l]),
         .res  (lane_res[l])
      );
   end
endmodule

// File: doc/jpeg_dequant.md
# jpeg_dequant

Streaming inverse quantizer for the JPEG accelerator's decode path. It accepts 32-bit words carrying two signed 16-bit quantized DCT coefficients. Each coefficient is multiplied by its entry from a loadable 64-entry quantization table, and the resulting pair is emitted in the same packed format, ready for the IDCT. It is the decode-side counterpart of the reciprocal-multiply quantizer: it multiplies by Q directly, so no rounding is involved.

## Interface
Parameters:
- QW, 8, quantization table entry width (unsigned, baseline JPEG).
- BLK_WORDS, 32, packed words per 8x8 block (64 coefficients / 2).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- qt_we_i  in  1  table write strobe.
- qt_addr_i  in  6  table index, natural (row-major) coefficient order.
- qt_dat_i  in  QW  table value.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  block can accept input this cycle.
- in_dat_i  in  32  [31:16] = coefficient 2k, [15:0] = coefficient 2k+1, signed.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  downstream accepts output.
- out_dat_o  out  32  dequantized pair, same packing.
- out_last_o  out  1  qualifies out_dat_o as word BLK_WORDS-1 of a block.
- busy_o  out  1  a block is in progress or the pipeline is non-empty.

## Operation
- Table: 64 x QW register array. Reset loads every entry with 1, which gives identity dequantization.
- Table writes are accepted only when busy_o=0. A write with busy_o=1 is ignored with no side effects.
- Word counter wcnt (5 bits):
  - Increments on each input handshake (in_valid_i & in_ready_o).
  - Wraps from 31 to 0.
  - Selects table entries 2*wcnt (high half) and 2*wcnt+1 (low half).
- Pipeline: 2 stages sharing one enable, en = !out_valid_o | out_ready_i.
  - S1 registers the coefficient pair, the two table values, and last = (wcnt==31). Table values are read combinationally at handshake time.
  - S2 registers the products, the valid bit, and last.
- Arithmetic:
  - Each half is signed 16 x unsigned QW, giving a signed 16+QW+1-bit product. The table value is zero-extended.
  - Output width handling depends on DEQUANT_SAT_EN (see Configuration).
- in_ready_o = en. The whole pipeline stalls when the output is held. Bubbles (in_valid_i=0) propagate as invalid slots.
- busy_o = (wcnt!=0) | s1_valid | out_valid_o.
- A Q value of 0 is legal and produces 0.

## Timing
- Latency: an input handshake in cycle n presents data with out_valid_o=1 in cycle n+2, if out_ready_i is held high.
- Throughput: one word per cycle sustained.
- Output hold: while out_valid_o=1 & out_ready_i=0, out_dat_o and out_last_o are held stable and in_ready_o=0.
- Back-to-back blocks: word 0 of the next block may be accepted in the cycle after word 31. Table values cannot change between those two blocks while the pipeline is non-empty.
- Table write visibility: a table write in cycle n is visible to a handshake in cycle n+1.
- Reset, including mid-block: one cycle of rst_i gives:
  - wcnt=0.
  - s1_valid=0, out_valid_o=0, out_dat_o=0, out_last_o=0, busy_o=0.
  - Table reloaded to all 1s.
  - Partial block discarded.
  - in_ready_o=1 in the first cycle after reset.
- Simultaneous qt_we_i and input handshake with busy_o=0: the handshake uses the old table value. The write is accepted only if busy_o=0 in that cycle, which it is.

## Configuration
- DEQUANT_SAT_EN defined:
  - Each product is saturated to [-32768, 32767].
  - Out-of-range results clamp to the nearest bound.
- Undefined:
  - Each product is truncated to its low 16 bits (two's complement wrap).
  - Saturation logic is not instantiated.

## Test plan
- Reset default: after reset, stream 32 words, each 0x0005FFFD. Every output equals 0x0005FFFD (Q=1). out_last_o is high only on the 32nd output. First output appears 2 cycles after the first handshake.
- Table load: write Q[0]=16 and Q[1]=11 while idle, then send 0x0003FFFE as word 0. Output is 0x0030FFEA (3*16=48, -2*11=-22).
- Saturation: with Q[2]=255, send word 1 = 0x7FFF0000. With DEQUANT_SAT_EN defined, output is 0x7FFF0000. Without it, output is 0x7F010000 (32767*255 = 0x7F7F01, low 16 bits 0x7F01).
- Backpressure: stream 32 words with out_ready_i toggling 1,0,0,1. No word is lost or duplicated, outputs stay in order, and out_dat_o is stable during every stall cycle.
- Busy write lockout: after 5 words of a block, attempt qt_we_i with Q[10]=99. Word 5 uses the old Q[10]. After the block completes and busy_o=0, Q[10] still reads back as the old value.
- Mid-block reset: send 12 words, then assert rst_i for 1 cycle. out_valid_o=0 next cycle. A following full block wraps correctly, with out_last_o on its 32nd output, using Q=1.
